// File: rtl/fp16_dot_issuer.sv
// FP16 dot-product issuer: streams buffered operand pairs into an external pipelined
// MAC, then captures the accumulator output that lines up with the final beat.
module fp16_dot_issuer #(
  parameter int DEPTH    = 16,
  parameter int PIPE_LAT = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [15:0]              wr_a,
  input  logic [15:0]              wr_b,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              result,
  output logic                     err,
  output logic                     mac_ivalid,
  output logic                     mac_control,
  output logic [15:0]              mac_a,
  output logic [15:0]              mac_b,
  input  logic                     mac_iready,
  input  logic                     mac_ovalid,
  input  logic [15:0]              mac_dataout
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_n_s;
  logic [15:0]         buf_a_r [DEPTH];
  logic [15:0]         buf_b_r [DEPTH];
  logic [IW-1:0]       idx_r;
  logic [LW-1:0]       len_r;
  logic [PIPE_LAT-1:0] last_sr_r;
  logic                mac_last_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                mac_ivalid_r;
  logic                mac_control_r;
  logic [15:0]         result_r;
  logic [15:0]         mac_a_r;
  logic [15:0]         mac_b_r;
  logic                start_ok_s;
  logic                start_bad_s;
  logic                beat_s;
  logic                final_s;
  logic                finish_s;

  // Next-state and per-cycle event decode.
  always_comb begin
    state_n_s   = state_r;
    start_ok_s  = 1'b0;
    start_bad_s = 1'b0;
    beat_s      = 1'b0;
    final_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((len != {LW{1'b0}}) && (len <= LW'(DEPTH))) begin
            start_ok_s = 1'b1;
            state_n_s  = ISSUE;
          end else begin
            start_bad_s = 1'b1;
            state_n_s   = IDLE;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      ISSUE: begin
        if (mac_iready) begin
          beat_s  = 1'b1;
          final_s = ({1'b0, idx_r} == (len_r - LW'(1'b1)));
          if (final_s) begin
            state_n_s = DRAIN;
          end else begin
            state_n_s = ISSUE;
          end
        end else begin
          state_n_s = ISSUE;
        end
      end
      DRAIN: begin
        // The last-flag pipe tracks the MAC latency, so its output marks the final sum.
        if (last_sr_r[PIPE_LAT-1]) begin
          finish_s  = 1'b1;
          state_n_s = IDLE;
        end else begin
          state_n_s = DRAIN;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Control state, registered MAC beat outputs and run status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= {IW{1'b0}};
      len_r         <= {LW{1'b0}};
      last_sr_r     <= {PIPE_LAT{1'b0}};
      mac_last_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      mac_ivalid_r  <= 1'b0;
      mac_control_r <= 1'b0;
      result_r      <= 16'h0000;
      mac_a_r       <= 16'h0000;
      mac_b_r       <= 16'h0000;
    end else begin
      state_r       <= state_n_s;
      busy_r        <= (state_n_s != IDLE);
      done_r        <= finish_s;
      mac_ivalid_r  <= beat_s;
      mac_control_r <= beat_s && (idx_r == {IW{1'b0}});
      mac_last_r    <= beat_s && final_s;
      last_sr_r[0]  <= mac_last_r;
      for (int i = 1; i < PIPE_LAT; i++) begin
        last_sr_r[i] <= last_sr_r[i-1];
      end
      if (start_ok_s) begin
        len_r <= len;
        idx_r <= {IW{1'b0}};
      end else if (beat_s) begin
        idx_r <= idx_r + IW'(1'b1);
      end
      if (beat_s) begin
        mac_a_r <= buf_a_r[idx_r];
        mac_b_r <= buf_b_r[idx_r];
      end
      if (start_ok_s) begin
        err_r <= 1'b0;
      end else if (start_bad_s || (finish_s && !mac_ovalid)) begin
        err_r <= 1'b1;
      end
      if (finish_s && mac_ovalid) begin
        result_r <= mac_dataout;
      end
    end
  end

  // Operand buffer, writable only while idle; intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en && (state_r == IDLE)) begin
      buf_a_r[wr_addr] <= wr_a;
      buf_b_r[wr_addr] <= wr_b;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign result      = result_r;
  assign mac_ivalid  = mac_ivalid_r;
  assign mac_control = mac_control_r;
  assign mac_a       = mac_a_r;
  assign mac_b       = mac_b_r;

endmodule

// File: tb/tb_fp16_dot_issuer.sv
// Scoreboard bench for fp16_dot_issuer with a fixed-latency fake MAC.
module tb_fp16_dot_issuer;
  localparam int DEPTH    = 16;
  localparam int PIPE_LAT = 6;
  localparam int IW       = 4;
  localparam int LW       = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [15:0]   wr_a = '0;
  logic [15:0]   wr_b = '0;
  logic [LW-1:0] len = '0;
  logic          start = 1'b0;
  logic          mac_iready = 1'b1;
  logic [15:0]   mac_dataout = '0;
  logic          mac_ovalid;
  logic          busy, done, err, mac_ivalid, mac_control;
  logic [15:0]   result, mac_a, mac_b;

  typedef struct {logic ctrl; logic [15:0] a; logic [15:0] b;} beat_t;
  typedef struct {logic [15:0] res; logic e; int cyc;} exp_t;

  beat_t beat_q[$];
  exp_t  exp_q[$];
  beat_t mb;
  exp_t  me;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    n_done = 0;
  bit    drop = 1'b0;
  logic [15:0] mdl_a [DEPTH];
  logic [15:0] mdl_b [DEPTH];
  logic [15:0] va [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                          16'h7BFF, 16'hC000, 16'h0001, 16'h8000};
  logic [15:0] vb [8] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                          16'h1234, 16'hFC00, 16'h7E00, 16'hABCD};
  logic [PIPE_LAT-1:0] vp;

  fp16_dot_issuer #(.DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_a(wr_a), .wr_b(wr_b), .len(len), .start(start), .busy(busy),
    .done(done), .result(result), .err(err), .mac_ivalid(mac_ivalid),
    .mac_control(mac_control), .mac_a(mac_a), .mac_b(mac_b),
    .mac_iready(mac_iready), .mac_ovalid(mac_ovalid), .mac_dataout(mac_dataout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Fake MAC: output valid PIPE_LAT cycles after each input beat.
  always @(posedge clock or posedge reset)
    if (reset) vp <= '0;
    else       vp <= {vp[PIPE_LAT-2:0], mac_ivalid};
  assign mac_ovalid = vp[PIPE_LAT-1] & ~drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every beat and every done pulse is checked against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (mac_ivalid) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_ctrl", mac_control, mb.ctrl);
          chk("beat_a", mac_a, mb.a);
          chk("beat_b", mac_b, mb.b);
          chk("busy_on_beat", busy, 1);
        end
      end else begin
        chk("ctrl_without_beat", mac_control, 0);
      end
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("result", result, me.res);
          chk("err_at_done", err, me.e);
          chk("done_cycle", cyc, me.cyc);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic write(input int addr, input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = addr[IW-1:0]; wr_a = a; wr_b = b;
    @(negedge clock);
    wr_en = 1'b0;
    mdl_a[addr] = a;
    mdl_b[addr] = b;
  endtask

  // Returns at the negedge of the cycle after the edge that samples start (edge e).
  task automatic pulse_start(input int n, output int e);
    @(negedge clock);
    start = 1'b1; len = n[LW-1:0]; e = cyc + 1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_run(input int n, input logic [15:0] res, input bit errx,
                          input int e, input int extra);
    for (int i = 0; i < n; i++) beat_q.push_back('{(i == 0), mdl_a[i], mdl_b[i]});
    exp_q.push_back('{res, errx, e + n + PIPE_LAT + 1 + extra});
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 300 && n_done < tgt; i++) @(negedge clock);
    if (n_done < tgt) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int n, input logic [15:0] mval, input logic [15:0] res,
                     input bit errx, input bit stall, input bit poke);
    int e, tgt;
    mac_dataout = mval;
    tgt = n_done + 1;
    pulse_start(n, e);
    push_run(n, res, errx, e, stall ? 2 : 0);
    chk("err_cleared_on_start", err, 0);
    chk("busy_after_start", busy, 1);
    if (stall || poke) begin
      while (cyc < e + 2) @(negedge clock);
      if (stall) mac_iready = 1'b0;
      if (poke) begin
        start = 1'b1; len = 5'd2;
        wr_en = 1'b1; wr_addr = '0; wr_a = 16'hDEAD; wr_b = 16'hBEEF;
      end
      @(negedge clock);
      start = 1'b0; wr_en = 1'b0;
      @(negedge clock);
      mac_iready = 1'b1;
    end
    wait_done(tgt);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ivalid", mac_ivalid, 0);
    chk("rst_ctrl", mac_control, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_mac_a", mac_a, 16'h0000);
    chk("rst_mac_b", mac_b, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) write(i, va[i], vb[i]);

    run(4, 16'h4A00, 16'h4A00, 1'b0, 1'b0, 1'b0);
    run(4, 16'h4B00, 16'h4B00, 1'b0, 1'b1, 1'b0);

    pulse_start(0, e);
    chk("err_len0", err, 1);
    chk("busy_len0", busy, 0);
    repeat (3) @(negedge clock);
    chk("busy_len0_later", busy, 0);
    pulse_start(17, e);
    chk("err_len17", err, 1);
    chk("busy_len17", busy, 0);
    run(2, 16'h4C00, 16'h4C00, 1'b0, 1'b0, 1'b0);

    drop = 1'b1;
    run(3, 16'h5555, 16'h4C00, 1'b1, 1'b0, 1'b0);
    drop = 1'b0;

    pulse_start(8, e);
    push_run(8, 16'h0000, 1'b0, e, 0);
    while (cyc < e + 2) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    beat_q.delete();
    exp_q.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_ivalid", mac_ivalid, 0);
    chk("midrst_ctrl", mac_control, 0);
    chk("midrst_result", result, 16'h0000);
    chk("midrst_mac_a", mac_a, 16'h0000);
    chk("midrst_mac_b", mac_b, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    for (int i = 0; i < 8; i++) write(i, va[i], vb[i]);
    run(8, 16'h5140, 16'h5140, 1'b0, 1'b0, 1'b0);

    run(4, 16'h4D00, 16'h4D00, 1'b0, 1'b0, 1'b1);
    run(4, 16'h4E00, 16'h4E00, 1'b0, 1'b0, 1'b0);

    for (int i = 8; i < DEPTH; i++) write(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
    run(16, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clock);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
